// File: rtl/operand_select_stage.sv
// operand_select_stage
//   Decode-to-execute boundary of the RV32I pipeline. Selects each ALU operand
//   from the register file, a 1-back forward (current EX result), a 2-back
//   forward (previous EX result) or the immediate. It then registers the
//   operands with the control bundle into the ID/EX pipeline register.
//   Stall, flush or an empty ID slot loads a bubble. Stall/flush bubbles are
//   counted in a saturating debug counter.
//
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   stall_in, flush_in      : bubble requests (both are counted)
//   valid_in                : ID holds a real instruction
//   irmux1 / irmux2         : operand select codes from the bypass unit
//   rs1_data, rs2_data      : register-file read data
//   imm_in, pc_in           : decoded immediate, PC of the ID instruction
//   rd_in, ctrl_in          : destination register, decoded control bundle
//   alu_result_in           : combinational ALU result of the EX instruction
//   op_a, op_b              : registered EX operands
//   ex_pc, ex_rd, ex_ctrl   : registered PC / rd / control (zero for a bubble)
//   ex_valid                : EX holds a real instruction
//   bubble_count            : saturating count of stall/flush bubbles
module operand_select_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              valid_in,
  input  logic [1:0]        irmux1,
  input  logic [1:0]        irmux2,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [4:0]        rd_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [XLEN-1:0]   alu_result_in,
  output logic [XLEN-1:0]   op_a,
  output logic [XLEN-1:0]   op_b,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_valid,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef enum logic [1:0] {
    SEL_REG  = 2'b00,
    SEL_FWD1 = 2'b01,
    SEL_FWD2 = 2'b10,
    SEL_ALT  = 2'b11
  } sel_e;

  logic [XLEN-1:0] res_d1;
  logic [XLEN-1:0] op_a_next;
  logic [XLEN-1:0] op_b_next;
  logic            bubble;
  logic            count_bubble;
  sel_e            sel1;
  sel_e            sel2;

  assign sel1         = sel_e'(irmux1);
  assign sel2         = sel_e'(irmux2);
  assign bubble       = stall_in | flush_in | ~valid_in;
  assign count_bubble = stall_in | flush_in;

  always_comb begin
    op_a_next = rs1_data;
    unique case (sel1)
      SEL_FWD1: op_a_next = alu_result_in;
      SEL_FWD2: op_a_next = res_d1;
      default:  op_a_next = rs1_data;  // 11 is reserved on rs1 and reads the reg file
    endcase
  end

  always_comb begin
    op_b_next = rs2_data;
    unique case (sel2)
      SEL_FWD1: op_b_next = alu_result_in;
      SEL_FWD2: op_b_next = res_d1;
      SEL_ALT:  op_b_next = imm_in;
      default:  op_b_next = rs2_data;
    endcase
  end

  // The history register updates even during bubbles. It must always hold the
  // result of whatever instruction just left EX.
  always_ff @(posedge clk) begin
    if (reset) res_d1 <= '0;
    else       res_d1 <= alu_result_in;
  end

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      op_a     <= '0;
      op_b     <= '0;
      ex_pc    <= '0;
      ex_rd    <= '0;
      ex_ctrl  <= '0;
      ex_valid <= 1'b0;
    end else begin
      op_a     <= op_a_next;
      op_b     <= op_b_next;
      ex_pc    <= pc_in;
      ex_rd    <= rd_in;
      ex_ctrl  <= ctrl_in;
      ex_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      bubble_count <= '0;
    else if (count_bubble && (bubble_count != '1))
      bubble_count <= bubble_count + 1'b1;
  end

endmodule

// File: doc/operand_select_stage.md
# operand_select_stage

Decode-to-execute stage boundary of the RV32I pipeline: consumes the per-operand select codes produced by the bypass unit, picks each ALU operand from the register file, a forwarded result or the immediate, and registers them with the instruction's control bundle into the ID/EX pipeline register. It keeps a one-deep history of ALU results for two-back forwarding. On stall or branch flush it inserts bubbles, and it counts inserted bubbles for debug.

## Interface
Parameters:
- XLEN, 32, datapath width
- CTRL_W, 8, width of the decoded control bundle carried to EX
- CNT_W, 16, width of the bubble counter

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, sampled on rising edge of clk
- stall_in  in  1  bypass-unit stall; insert bubble this cycle
- flush_in  in  1  taken branch/jump (SB/UJ resolve); insert bubble this cycle
- valid_in  in  1  ID holds a real instruction
- irmux1  in  2  rs1 select: 00 reg file, 01 fwd 1-back, 10 fwd 2-back, 11 reserved (treated as 00)
- irmux2  in  2  rs2 select: 00 reg file, 01 fwd 1-back, 10 fwd 2-back, 11 immediate
- rs1_data, rs2_data  in  XLEN  register-file read data
- imm_in  in  XLEN  decoded immediate
- pc_in  in  XLEN  PC of ID instruction
- rd_in  in  5  destination register
- ctrl_in  in  CTRL_W  decoded control bundle
- alu_result_in  in  XLEN  combinational ALU result of instruction currently in EX
- op_a, op_b  out  XLEN  registered EX operands
- ex_pc  out  XLEN  registered PC
- ex_rd  out  5  registered rd (0 for bubble)
- ex_ctrl  out  CTRL_W  registered control (0 for bubble)
- ex_valid  out  1  EX holds a real instruction
- bubble_count  out  CNT_W  saturating count of inserted bubbles

## Operation
- Internal history register res_d1 <= alu_result_in every non-reset cycle, unconditionally (also during stall/flush) so it tracks the instruction that left EX.
- Operand mux (combinational, before ID/EX register):
  - fwd 1-back source = alu_result_in; fwd 2-back source = res_d1.
  - op_a_next per irmux1; code 11 selects rs1_data.
  - op_b_next per irmux2; code 11 selects imm_in.
- Bubble condition: bubble = stall_in | flush_in | ~valid_in.
- Normal load (bubble=0): op_a<=op_a_next, op_b<=op_b_next, ex_pc<=pc_in, ex_rd<=rd_in, ex_ctrl<=ctrl_in, ex_valid<=1.
- Bubble load: op_a, op_b, ex_pc, ex_rd, ex_ctrl <= 0; ex_valid <= 0.
- bubble_count increments by exactly 1 when (stall_in | flush_in) is high, regardless of valid_in; ~valid_in alone does not count. Saturates at all-ones; no wrap.
- Stall and flush simultaneously: single bubble, counter +1.
- No internal FSM beyond the history register and counter; stage is a pure registered slice with bubble insertion. IF/ID hold during stall is owned by the fetch stage, not this block.

## Timing
- Latency: 1 cycle from ID inputs to EX outputs; all outputs registered, no combinational input-to-output path.
- Forwarding values must be sampled at the same edge as the select codes: alu_result_in and res_d1 as seen in cycle N pair with irmux1/irmux2 of cycle N.
- Reset (synchronous): next edge forces op_a, op_b, ex_pc, ex_ctrl, res_d1, bubble_count = 0, ex_rd = 0, ex_valid = 0. Reset has priority over stall/flush/valid.
- Reset mid-operation: in-flight ID/EX contents and history are discarded; first post-reset edge with valid_in=1 and no stall loads normally; a 2-back forward in that cycle reads res_d1 = value of alu_result_in from the reset-release cycle.
- Counter at all-ones with further bubbles: stays all-ones.

## Test plan
- Reset: assert reset 2 cycles with random inputs -> all outputs 0, ex_valid=0, bubble_count=0; first cycle after release with valid_in=1, irmux=00, rs1=0x11, rs2=0x22 -> op_a=0x11, op_b=0x22, ex_valid=1.
- Forwarding: cycle N alu_result_in=0xAAAA0001, cycle N+1 alu_result_in=0xBBBB0002 with irmux1=10, irmux2=01 -> op_a=0xAAAA0001, op_b=0xBBBB0002 after edge N+1.
- Immediate: irmux2=11, imm_in=0xFFFFF800, rs2_data=0x5 -> op_b=0xFFFFF800; irmux1=11, rs1_data=0x7 -> op_a=0x7.
- Stall/flush: stall_in=1 one cycle, then flush_in=1 one cycle, then both together one cycle -> three bubbles (ex_valid=0, ex_rd=0, ex_ctrl=0), bubble_count=3; res_d1 still follows alu_result_in (verify via 2-back forward next cycle).
- Invalid ID: valid_in=0, no stall/flush -> bubble inserted, bubble_count unchanged.
- Saturation: CNT_W=4 build, 20 consecutive stall cycles -> bubble_count=0xF, holds at 0xF.
